branch_target_lut: RTL and testbench

BRANCH_TARGET_LUT -- requirements
Module: branch_target_lut

---
 rtl/branch_target_pkg.sv | 24 ++
 rtl/btl_store.sv | 46 ++++
 rtl/branch_target_lut.sv | 150 +++++++++++++++
 tb/tb_branch_target_lut.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_target_pkg.sv
`default_nettype none
// ============================================================================
// branch_target_pkg : FSM state encoding and default sizing shared by the
//                     branch target lookup table and its storage.
// Rev 1.0
// ============================================================================
package branch_target_pkg;

    localparam int c_DEF_D     = 10;
    localparam int c_DEF_A     = 8;
    localparam int c_DEF_DEPTH = 16;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } btl_state_e;

    // Index width able to address every entry; a one-bit index is the floor.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btl_store.sv
`default_nettype none
// ============================================================================
// btl_store : target/valid storage, one write port and one registered read
//             port. No reset: the owner sweeps it clean before use.
// Rev 1.0
// ============================================================================
module btl_store
    import branch_target_pkg::*;
#(
    parameter int D     = c_DEF_D,
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [D-1:0]  i_wdata,
    input  logic          i_wvalid,
    input  logic          i_re,
    input  logic [IW-1:0] i_raddr,
    output logic [D-1:0]  o_rdata,
    output logic          o_rvalid
);

    logic [D-1:0]     r_target [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [D-1:0]     r_rdata;
    logic             r_rvalid;

    // Read and write on the same edge: the read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_target[i_waddr] <= i_wdata;
            r_valid[i_waddr]  <= i_wvalid;
        end
        if (i_re) begin
            r_rdata  <= r_target[i_raddr];
            r_rvalid <= r_valid[i_raddr];
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: rtl/branch_target_lut.sv
`default_nettype none
// ============================================================================
// branch_target_lut : registered branch-target lookup table with a clearing
//                     sweep. BRANCH_TARGET_LUT_FWD_EN enables write-to-lookup
//                     forwarding for a same-cycle same-index hit.
// Rev 1.0
// ============================================================================
module branch_target_lut
    import branch_target_pkg::*;
#(
    parameter int D     = c_DEF_D,
    parameter int A     = c_DEF_A,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         branch,
    input  logic [A-1:0] addr,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         clear,
    output logic [D-1:0] target,
    output logic         hit,
    output logic         wr_ack,
    output logic         busy
);

    localparam int            IW        = idx_width(DEPTH);
    localparam logic [A:0]    c_DEPTH_W = (A+1)'(DEPTH);
    localparam logic [IW-1:0] c_LAST    = IW'(DEPTH - 1);

    btl_state_e    r_state;
    logic [IW-1:0] r_sweep_idx;
    logic          r_busy;
    logic          r_wr_ack;
    logic          r_lookup_live;

    logic          w_rd_in_range;
    logic          w_wr_in_range;
    logic          w_lookup_ok;
    logic          w_wr_accept;
    logic          w_sweeping;

    logic          w_st_we;
    logic [IW-1:0] w_st_waddr;
    logic [D-1:0]  w_st_wdata;
    logic          w_st_wvalid;
    logic [D-1:0]  w_rd_data;
    logic          w_rd_valid;
    logic          w_store_hit;

    assign w_rd_in_range = ({1'b0, addr}    < c_DEPTH_W);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_W);
    assign w_sweeping    = (r_state == CLEAR);
    assign w_lookup_ok   = branch && w_rd_in_range && !w_sweeping;
    assign w_wr_accept   = wr_en  && w_wr_in_range && !w_sweeping;

    // The sweep owns the write port for the whole of CLEAR.
    assign w_st_we     = w_sweeping || w_wr_accept;
    assign w_st_waddr  = w_sweeping ? r_sweep_idx : wr_addr[IW-1:0];
    assign w_st_wdata  = w_sweeping ? '0 : wr_data;
    assign w_st_wvalid = !w_sweeping;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= CLEAR;
            r_sweep_idx   <= '0;
            r_busy        <= 1'b1;
            r_wr_ack      <= 1'b0;
            r_lookup_live <= 1'b0;
        end else begin
            r_wr_ack      <= w_wr_accept;
            r_lookup_live <= w_lookup_ok;
            case (r_state)
                CLEAR: begin
                    if (clear) begin
                        r_sweep_idx <= '0;
                    end else if (r_sweep_idx == c_LAST) begin
                        r_state     <= READY;
                        r_sweep_idx <= '0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + 1'b1;
                    end
                end
                READY: begin
                    if (clear) begin
                        r_state     <= CLEAR;
                        r_sweep_idx <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_sweep_idx <= '0;
                    r_busy      <= 1'b1;
                end
            endcase
        end
    end

    btl_store #(
        .D     (D),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_store (
        .clk      (Clk),
        .i_we     (w_st_we),
        .i_waddr  (w_st_waddr),
        .i_wdata  (w_st_wdata),
        .i_wvalid (w_st_wvalid),
        .i_re     (w_lookup_ok),
        .i_raddr  (addr[IW-1:0]),
        .o_rdata  (w_rd_data),
        .o_rvalid (w_rd_valid)
    );

    // Store data is only trusted for a cycle that followed a real lookup.
    assign w_store_hit = r_lookup_live && w_rd_valid;

`ifdef BRANCH_TARGET_LUT_FWD_EN
    logic         w_fwd;
    logic         r_fwd_hit;
    logic [D-1:0] r_fwd_data;

    assign w_fwd = w_lookup_ok && w_wr_accept && (addr == wr_addr);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit  <= w_fwd;
            r_fwd_data <= w_fwd ? wr_data : '0;
        end
    end

    assign hit    = r_fwd_hit || w_store_hit;
    assign target = r_fwd_hit ? r_fwd_data : (w_store_hit ? w_rd_data : '0);
`else
    assign hit    = w_store_hit;
    assign target = w_store_hit ? w_rd_data : '0;
`endif

    assign wr_ack = r_wr_ack;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_lut.sv
`default_nettype none
// ============================================================================
// tb_branch_target_lut : directed vectors with a queued scoreboard; a monitor
//                        pops one expectation per clock and compares.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_branch_target_lut;

    logic       Clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic       branch  = 1'b0;
    logic [7:0] addr    = '0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [9:0] wr_data = '0;
    logic       clear   = 1'b0;
    logic [9:0] target;
    logic       hit;
    logic       wr_ack;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BRANCH_TARGET_LUT_FWD_EN
    localparam logic [9:0] c_SAME = 10'd100;
`else
    localparam logic [9:0] c_SAME = 10'd281;
`endif

    always #5 Clk = ~Clk;

    branch_target_lut #(.D(10), .A(8), .DEPTH(16)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .branch  (branch),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clear   (clear),
        .target  (target),
        .hit     (hit),
        .wr_ack  (wr_ack),
        .busy    (busy)
    );

    typedef struct {
        string      nm;
        bit         cl;
        logic [9:0] t;
        bit         h;
        bit         ca;
        bit         a;
        bit         cb;
        bit         b;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input string nm, input bit cl, input logic [9:0] t, input bit h,
                                input bit ca, input bit a, input bit cb, input bit b);
        exp_t e;
        e.nm = nm; e.cl = cl; e.t = t; e.h = h;
        e.ca = ca; e.a = a; e.cb = cb; e.b = b;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic step(input bit br, input logic [7:0] ad, input bit we, input logic [7:0] wa,
                        input logic [9:0] wd, input bit cl, input exp_t e);
        @(negedge Clk);
        branch = br; addr = ad; wr_en = we; wr_addr = wa; wr_data = wd; clear = cl;
        sb.push_back(e);
    endtask

    task automatic idle(input exp_t e);
        step(1'b0, 8'd0, 1'b0, 8'd0, 10'd0, 1'b0, e);
    endtask

    // 16 cycles after Reset release: busy high through edge 15, low after edge 16.
    task automatic sweep_after_reset(input string nm);
        for (int k = 1; k <= 16; k++)
            step(k == 1, 8'd3, 1'b0, 8'd0, 10'd0, 1'b0,
                 mk(nm, k == 1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, k < 16));
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_target"}, target, 0);
        check({nm, "_hit"},    hit,    0);
        check({nm, "_wr_ack"}, wr_ack, 0);
        check({nm, "_busy"},   busy,   1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cl) begin
                    check({e.nm, "_target"}, target, e.t);
                    check({e.nm, "_hit"},    hit,    e.h);
                end
                if (e.ca) check({e.nm, "_wr_ack"}, wr_ack, e.a);
                if (e.cb) check({e.nm, "_busy"},   busy,   e.b);
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: run did not complete, queue depth %0d, required 0", sb.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stimulus
        @(posedge Clk);
        #2;
        check_reset_state("reset");
        Reset = 1'b0;
        sweep_after_reset("sweep1");

        step(0, 0, 1, 5, 10'd281, 0, mk("wr5", 0, 0, 0, 1, 1, 1, 0));
        idle(mk("wr5_pulse_end", 0, 0, 0, 1, 0, 0, 0));
        step(1, 5, 0, 0, 0, 0, mk("lu5", 1, 10'd281, 1, 1, 0, 0, 0));
        idle(mk("branch0_after_hit", 1, 0, 0, 0, 0, 0, 0));
        step(1, 20, 0, 0, 0, 0, mk("lu20", 1, 0, 0, 0, 0, 0, 0));
        step(0, 0, 1, 20, 10'd77, 0, mk("wr20", 0, 0, 0, 1, 0, 0, 0));
        step(1, 4, 0, 0, 0, 0, mk("lu4_no_alias", 1, 0, 0, 0, 0, 0, 0));
        step(1, 5, 1, 5, 10'd100, 0, mk("same_cycle", 1, c_SAME, 1, 1, 1, 0, 0));
        step(1, 5, 0, 0, 0, 0, mk("lu5_new", 1, 10'd100, 1, 1, 0, 0, 0));
        step(0, 0, 1, 15, 10'd1023, 0, mk("wr15", 0, 0, 0, 1, 1, 0, 0));
        step(1, 15, 0, 0, 0, 0, mk("lu15", 1, 10'd1023, 1, 0, 0, 0, 0));
        step(0, 0, 1, 0, 10'd1, 0, mk("wr0", 0, 0, 0, 1, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, mk("lu0", 1, 10'd1, 1, 0, 0, 0, 0));

        // clear from READY, then Reset once the sweep index reaches 7
        step(1, 15, 0, 0, 0, 1, mk("lu_with_clear", 1, 10'd1023, 1, 0, 0, 1, 1));
        step(0, 0, 1, 3, 10'd55, 0, mk("wr_in_clear", 0, 0, 0, 1, 0, 1, 1));
        step(1, 0, 0, 0, 0, 0, mk("lu_in_clear", 1, 0, 0, 0, 0, 1, 1));
        for (int k = 0; k < 5; k++) idle(mk("clear_busy", 0, 0, 0, 0, 0, 1, 1));
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        branch = 0; wr_en = 0; clear = 0;
        #1;
        check_reset_state("midsweep_reset");
        repeat (2) @(posedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        sweep_after_reset("sweep2");
        step(1, 5, 0, 0, 0, 0, mk("lu5_after_reset", 1, 0, 0, 0, 0, 0, 0));
        step(1, 15, 0, 0, 0, 0, mk("lu15_after_reset", 1, 0, 0, 0, 0, 0, 0));
        step(1, 3, 0, 0, 0, 0, mk("lu3_after_reset", 1, 0, 0, 0, 0, 0, 0));

        // clear during CLEAR restarts the 16-cycle sweep
        step(0, 0, 0, 0, 0, 1, mk("clear_a", 0, 0, 0, 0, 0, 1, 1));
        for (int k = 0; k < 3; k++) idle(mk("clear_a_busy", 0, 0, 0, 0, 0, 1, 1));
        step(0, 0, 0, 0, 0, 1, mk("clear_b", 0, 0, 0, 0, 0, 1, 1));
        for (int k = 1; k <= 16; k++) idle(mk("restart_busy", 0, 0, 0, 0, 0, 1, k < 16));
        step(0, 0, 1, 7, 10'd9, 0, mk("wr7", 0, 0, 0, 1, 1, 1, 0));
        step(1, 7, 0, 0, 0, 0, mk("lu7", 1, 10'd9, 1, 1, 0, 0, 0));

        repeat (2) @(posedge Clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
